// File: rtl/ws2812_frame_streamer.sv
// rtl/ws2812_frame_streamer.sv - WS2812 frame sequencer: pixel RAM fetch, GRB reorder, serializer start/done handshake
// Optional build macro WS2812_BRIGHTNESS_EN: scale each channel by (Brightness+1)/256 before reordering.
module ws2812_frame_streamer #(
    parameter int NUM_LEDS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BITWIDTH   = 24,
    parameter int TIMEOUT    = 20000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  FrameStart,
    input  logic [7:0]            Brightness,
    output logic [ADDR_WIDTH-1:0] RdAddr,
    input  logic [BITWIDTH-1:0]   RdData,
    output logic [BITWIDTH-1:0]   PixelWord,
    output logic                  PixelStart,
    input  logic                  PixelDone,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic                  Error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT,
        FINISH
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   idx, idx_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    err_q, err_d;
    logic                    load_en;
    logic [7:0]              chan_r, chan_g, chan_b;

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = 16'(c) * 16'({1'b0, br} + 9'd1);
        return prod[15:8];
    endfunction

    assign chan_r = scale(RdData[23:16], Brightness);
    assign chan_g = scale(RdData[15:8],  Brightness);
    assign chan_b = scale(RdData[7:0],   Brightness);
`else
    logic unused_brightness;

    assign unused_brightness = ^Brightness;
    assign chan_r = RdData[23:16];
    assign chan_g = RdData[15:8];
    assign chan_b = RdData[7:0];
`endif

    // Wire order is G, R, B with each byte MSB first; the serializer shifts out bit 0 first.
    function automatic logic [23:0] to_wire(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [23:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i]      = g[7-i];
            w[8 + i]  = r[7-i];
            w[16 + i] = b[7-i];
        end
        return w;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            PixelWord <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
            err_q <= err_d;
            if (load_en) begin
                PixelWord <= to_wire(chan_r, chan_g, chan_b);
            end
        end
    end

    assign RdAddr = idx;
    assign Error  = err_q;

    // The counter runs from the PixelStart cycle, so an abort lands exactly TIMEOUT cycles after it.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        cnt_d      = '0;
        err_d      = err_q;
        load_en    = 1'b0;
        PixelStart = 1'b0;
        Busy       = 1'b1;
        FrameDone  = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (FrameStart) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = START;
            end
            START: begin
                PixelStart = 1'b1;
                cnt_d      = cnt + CNT_W'(1);
                state_d    = WAIT;
            end
            WAIT: begin
                cnt_d = cnt + CNT_W'(1);
                if (PixelDone) begin
                    cnt_d = '0;
                    if (idx == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx + ADDR_WIDTH'(1);
                        state_d = FETCH;
                    end
                end else if (cnt == TIMEOUT_M1) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FINISH: begin
                FrameDone = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// tb/tb_ws2812_frame_streamer.sv - randomized self-checking bench for ws2812_frame_streamer
// Honours WS2812_BRIGHTNESS_EN in its reference model.
module tb_ws2812_frame_streamer;

    localparam int NUM_LEDS   = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int TIMEOUT    = 50;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  FrameStart;
    logic [7:0]            Brightness;
    logic [ADDR_WIDTH-1:0] RdAddr;
    logic [23:0]           RdData;
    logic [23:0]           PixelWord;
    logic                  PixelStart;
    logic                  PixelDone;
    logic                  Busy;
    logic                  FrameDone;
    logic                  Error;

    logic [23:0] mem      [NUM_LEDS];
    logic [23:0] cap_word [NUM_LEDS];
    int          lat_tab  [NUM_LEDS];
    int          br_tab   [3] = '{127, 255, 0};
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    ws2812_frame_streamer #(
        .NUM_LEDS   (NUM_LEDS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BITWIDTH   (24),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .FrameStart (FrameStart),
        .Brightness (Brightness),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .PixelWord  (PixelWord),
        .PixelStart (PixelStart),
        .PixelDone  (PixelDone),
        .Busy       (Busy),
        .FrameDone  (FrameDone),
        .Error      (Error)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) RdData <= mem[RdAddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expected, cyc);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Reference: scale each channel, lay out G,R,B as a 24-bit number, then send it MSB first from bit 0.
    function automatic logic [23:0] expect_word(input logic [23:0] rgb, input int br);
        int ch [3];
        int gain;
        logic [23:0] grb;
        logic [23:0] word;
        gain = br + 1;
`ifndef WS2812_BRIGHTNESS_EN
        gain = 256;
`endif
        ch[0] = rgb[15:8];
        ch[1] = rgb[23:16];
        ch[2] = rgb[7:0];
        for (int k = 0; k < 3; k++) ch[k] = (ch[k] * gain) / 256;
        grb = 24'(ch[0] * 65536 + ch[1] * 256 + ch[2]);
        for (int i = 0; i < 24; i++) word[i] = grb[23 - i];
        return word;
    endfunction

    // mode 0: normal frame, 1: stray FrameStart pulses, 2: withhold PixelDone on pixel sel, 3: reset mid-WAIT on pixel sel
    task automatic run_frame(input int mode, input int sel);
        int due = -1;
        int prev_start = -1;
        int last_done = -1;
        int t0;
        int n_start = 0;
        int n_fd = 0;
        bit finished = 1'b0;
        bit any_activity = 1'b0;
        FrameStart = 1'b1;
        t0 = cyc;
        step();
        FrameStart = 1'b0;
        check("busy_on_start", Busy, 1);
        check("rdaddr_on_start", RdAddr, 0);
        check("error_cleared", Error, 0);
        for (int k = 0; k < 3000 && !finished; k++) begin
            FrameStart = 1'b0;
            PixelDone  = (cyc == due);
            if (PixelDone) begin
                last_done = cyc;
                due = -1;
            end
            if (PixelStart) begin
                if (n_start >= NUM_LEDS) begin
                    check("start_count", n_start + 1, NUM_LEDS);
                end else begin
                    if (n_start == 0) check("first_start_delay", cyc - t0, 3);
                    else check("start_spacing", cyc - prev_start, lat_tab[n_start - 1] + 3);
                    check("rdaddr_at_start", RdAddr, n_start);
                    check("pixel_word", PixelWord, expect_word(mem[n_start], Brightness));
                    cap_word[n_start] = PixelWord;
                    if (!(mode == 2 && n_start == sel)) due = cyc + lat_tab[n_start];
                end
                prev_start = cyc;
                n_start++;
            end
            if (FrameDone) begin
                n_fd++;
                check("frame_done_delay", cyc - last_done, 1);
                check("frame_done_pixels", n_start, NUM_LEDS);
                if (mode == 1) FrameStart = 1'b1;
                finished = 1'b1;
            end
            if (mode == 2 && Error) begin
                check("timeout_delay", cyc - prev_start, TIMEOUT);
                check("busy_after_timeout", Busy, 0);
                check("timeout_pixel", n_start - 1, sel);
                finished = 1'b1;
            end
            if (mode == 1 && n_start == 2 && cyc == prev_start + 2) FrameStart = 1'b1;
            if (mode == 3 && n_start == sel + 1 && cyc == prev_start + 2) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                check("rst_rdaddr", RdAddr, 0);
                check("rst_pixel_word", PixelWord, 0);
                check("rst_pixel_start", PixelStart, 0);
                check("rst_busy", Busy, 0);
                check("rst_frame_done", FrameDone, 0);
                check("rst_error", Error, 0);
                for (int j = 0; j < 16; j++) begin
                    PixelDone = (cyc == due);
                    any_activity |= Busy | PixelStart | FrameDone;
                    step();
                end
                PixelDone = 1'b0;
                check("reset_ignores_done", any_activity, 0);
                finished = 1'b1;
            end
            step();
        end
        PixelDone = 1'b0;
        check("frame_finished", finished, 1);
        if (mode < 2) begin
            check("busy_after_frame", Busy, 0);
            check("frame_done_count", n_fd, 1);
        end else begin
            check("no_frame_done", n_fd, 0);
        end
    endtask

    task automatic fill_random(input int lat_lo, input int lat_hi);
        for (int i = 0; i < NUM_LEDS; i++) begin
            mem[i]     = 24'($urandom);
            lat_tab[i] = $urandom_range(lat_hi, lat_lo);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        FrameStart = 1'b0;
        PixelDone  = 1'b0;
        Brightness = 8'd0;
        fill_random(10, 10);
        repeat (3) step();
        check("reset_rdaddr", RdAddr, 0);
        check("reset_pixel_word", PixelWord, 0);
        check("reset_pixel_start", PixelStart, 0);
        check("reset_busy", Busy, 0);
        check("reset_frame_done", FrameDone, 0);
        check("reset_error", Error, 0);
        Reset = 1'b0;
        step();

        fill_random(10, 10);
        mem[0] = 24'h008000;
        mem[1] = 24'h010000;
        mem[2] = 24'h000001;
        Brightness = 8'd255;
        run_frame(0, 0);
        check("reorder_g", cap_word[0], 24'h000001);
        check("reorder_r", cap_word[1], 24'h008000);
        check("reorder_b", cap_word[2], 24'h800000);

        for (int f = 0; f < 4; f++) begin
            fill_random(1, TIMEOUT - 1);
            if (f == 0) begin
                lat_tab[3] = TIMEOUT - 1;
                lat_tab[5] = 1;
            end
            Brightness = 8'($urandom_range(255, 0));
            run_frame(0, 0);
        end

        for (int b = 0; b < 3; b++) begin
            fill_random(4, 4);
            mem[0] = 24'h00FF00;
            Brightness = 8'(br_tab[b]);
            run_frame(0, 0);
        end

        fill_random(10, 10);
        run_frame(1, 0);
        run_frame(0, 0);

        fill_random(3, 12);
        run_frame(2, $urandom_range(NUM_LEDS - 1, 0));
        repeat (3) step();
        check("error_sticky", Error, 1);
        check("idle_after_timeout", Busy, 0);
        run_frame(0, 0);

        fill_random(10, 10);
        run_frame(3, 3);
        run_frame(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
